// File: rtl/gcd_extract_pkg.sv
// Shared definitions for the Pollard p-1 GCD extraction stage.
package pm1_pkg;

    localparam int PM1_WIDTH = 64;

    typedef logic [2:0] gcd_state_t;

    localparam gcd_state_t ST_IDLE   = 3'd0;
    localparam gcd_state_t ST_PREP   = 3'd1;
    localparam gcd_state_t ST_STRIP  = 3'd2;
    localparam gcd_state_t ST_REDUCE = 3'd3;
    localparam gcd_state_t ST_SCALE  = 3'd4;
    localparam gcd_state_t ST_DONE   = 3'd5;

    // A factor is only useful when it is neither 1 nor the modulus itself.
    function automatic logic is_nontrivial(input logic [PM1_WIDTH-1:0] g,
                                           input logic [PM1_WIDTH-1:0] n);
        return (g > PM1_WIDTH'(1)) && (g < n);
    endfunction

endpackage

// File: rtl/gcd_extract_if.sv
// Handshake bundle between the exponentiation stage, gcd_extract and its consumer.
interface gcd_extract_if
    import pm1_pkg::*;
#(
    parameter int WIDTH = PM1_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] residue;
    logic [WIDTH-1:0] modulus;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] gcd;
    logic             factor_found;
    logic             busy;

    modport master (
        output in_valid, residue, modulus, out_ready,
        input  in_ready, out_valid, gcd, factor_found, busy
    );

    modport slave (
        input  in_valid, residue, modulus, out_ready,
        output in_ready, out_valid, gcd, factor_found, busy
    );

endinterface

// File: rtl/gcd_extract_step_unit.sv
// One binary-GCD step: common-factor stripping in STRIP, odd-x reduction in REDUCE.
module gcd_step_unit
    import pm1_pkg::*;
#(
    parameter int WIDTH = PM1_WIDTH,
    parameter int CNT_W = 7
) (
    input  gcd_state_t       state_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [CNT_W-1:0] k_i,
    output logic [WIDTH-1:0] x_o,
    output logic [WIDTH-1:0] y_o,
    output logic [CNT_W-1:0] k_o,
    output logic             both_even_o,
    output logic             x_zero_o,
    output logic             y_zero_o
);

    assign both_even_o = ~x_i[0] & ~y_i[0];
    assign x_zero_o    = (x_i == '0);
    assign y_zero_o    = (y_i == '0);

    // Next operand values for the current state; other states hold.
    always_comb begin
        x_o = x_i;
        y_o = y_i;
        k_o = k_i;
        case (state_i)
            ST_STRIP: begin
                if (both_even_o) begin
                    x_o = x_i >> 1;
                    y_o = y_i >> 1;
                    k_o = k_i + CNT_W'(1);
                end else if (!x_i[0]) begin
                    // Leave STRIP with x odd so REDUCE only ever halves y.
                    x_o = y_i;
                    y_o = x_i;
                end
            end
            ST_REDUCE: begin
                if (y_zero_o) begin
                    y_o = y_i;
                end else if (!y_i[0]) begin
                    y_o = y_i >> 1;
                end else if (x_i > y_i) begin
                    x_o = y_i;
                    y_o = x_i - y_i;
                end else begin
                    y_o = y_i - x_i;
                end
            end
            default: begin
                x_o = x_i;
            end
        endcase
    end

endmodule

// File: rtl/gcd_extract.sv
// g = gcd(r - 1, n) with a sequential binary GCD and a factor flag.
//
// state  | meaning
// IDLE   | waiting for a residue/modulus pair
// PREP   | resolve zero operands directly
// STRIP  | remove common powers of two, counting them in k
// REDUCE | subtract/halve with x odd until y reaches zero
// SCALE  | restore common powers of two: g = x << k
// DONE   | result presented until the consumer takes it
module gcd_extract
    import pm1_pkg::*;
#(
    parameter int WIDTH = PM1_WIDTH,
    parameter int CNT_W = 7
) (
    input  logic          clk,
    input  logic          rst,
    gcd_extract_if.slave  bus
);

    gcd_state_t       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic             factor_q, factor_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] x_step, y_step;
    logic [CNT_W-1:0] k_step;
    logic             both_even, x_zero, y_zero;

    gcd_step_unit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step (
        .state_i     (state_q),
        .x_i         (x_q),
        .y_i         (y_q),
        .k_i         (k_q),
        .x_o         (x_step),
        .y_o         (y_step),
        .k_o         (k_step),
        .both_even_o (both_even),
        .x_zero_o    (x_zero),
        .y_zero_o    (y_zero)
    );

    // FSM next state, operand updates and registered output values.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        k_d      = k_q;
        n_d      = n_q;
        gcd_d    = gcd_q;
        factor_d = factor_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    // r - 1 taken modulo n so a zero residue wraps to n - 1.
                    x_d     = (bus.residue == '0) ? bus.modulus - WIDTH'(1)
                                                  : bus.residue - WIDTH'(1);
                    y_d     = bus.modulus;
                    n_d     = bus.modulus;
                    k_d     = '0;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                if (x_zero) begin
                    gcd_d   = y_q;
                    state_d = ST_DONE;
                end else if (y_zero) begin
                    gcd_d   = x_q;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_STRIP;
                end
            end
            ST_STRIP: begin
                x_d = x_step;
                y_d = y_step;
                k_d = k_step;
                if (!both_even) begin
                    state_d = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                if (y_zero) begin
                    state_d = ST_SCALE;
                end else begin
                    x_d = x_step;
                    y_d = y_step;
                end
            end
            ST_SCALE: begin
                gcd_d   = x_q << k_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready && out_valid_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            factor_d = is_nontrivial(PM1_WIDTH'(gcd_d), PM1_WIDTH'(n_q));
        end

        out_valid_d = (state_d == ST_DONE);
        in_ready_d  = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            k_q         <= '0;
            n_q         <= '0;
            gcd_q       <= '0;
            factor_q    <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            k_q         <= k_d;
            n_q         <= n_d;
            gcd_q       <= gcd_d;
            factor_q    <= factor_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.gcd          = gcd_q;
    assign bus.factor_found = factor_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_gcd_extract.sv
// Testbench for gcd_extract.
module tb_gcd_extract;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    gcd_extract_if #(.WIDTH(64)) bus ();

    gcd_extract #(.WIDTH(64), .CNT_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] residue;
        logic [63:0] modulus;
        logic [63:0] exp_gcd;
        logic        exp_factor;
        int          exact_lat;
        int          max_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_gcd(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] t;
        while (b != 64'd0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic send_and_wait(input logic [63:0] r, input logic [63:0] n,
                                 output logic [63:0] g, output logic f,
                                 output int lat, output bit ok);
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        bus.residue  = r;
        bus.modulus  = n;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        ok = bus.out_valid;
        g  = bus.gcd;
        f  = bus.factor_found;
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    logic [63:0] g, r, n, a, b, x, eg;
    logic        f, ef;
    int          lat;
    bit          ok;

    initial begin
        errors        = 0;
        checks        = 0;
        bus.in_valid  = 1'b0;
        bus.residue   = '0;
        bus.modulus   = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_gcd", bus.gcd, 0);
        check("rst_factor", bus.factor_found, 0);

        vecs.push_back('{64'd98, 64'd8051, 64'd97, 1'b1, 0, 132});
        vecs.push_back('{64'd1, 64'd8051, 64'd8051, 1'b0, 2, 132});
        vecs.push_back('{64'd0, 64'd8051, 64'd1, 1'b0, 0, 132});
        vecs.push_back('{64'd2, 64'd8051, 64'd1, 1'b0, 0, 132});
        vecs.push_back('{64'd9, 64'd12, 64'd4, 1'b1, 0, 132});
        vecs.push_back('{64'd1 + (64'd1 << 20), 64'd1 << 40, 64'd1 << 20, 1'b1, 0, 132});
        vecs.push_back('{64'd8, 64'd35, 64'd7, 1'b1, 0, 132});
        vecs.push_back('{64'd0, 64'd1, 64'd1, 1'b0, 2, 132});
        vecs.push_back('{64'd5, 64'd0, 64'd4, 1'b0, 2, 132});
        vecs.push_back('{64'd20, 64'd12, 64'd1, 1'b0, 0, 132});
        vecs.push_back('{64'd13, 64'd12, 64'd12, 1'b0, 0, 132});

        for (int i = 0; i < vecs.size(); i++) begin
            send_and_wait(vecs[i].residue, vecs[i].modulus, g, f, lat, ok);
            check($sformatf("vec%0d_valid", i), ok, 1);
            if (ok) begin
                check($sformatf("vec%0d_gcd", i), g, vecs[i].exp_gcd);
                check($sformatf("vec%0d_factor", i), f, vecs[i].exp_factor);
                if (vecs[i].exact_lat != 0)
                    check($sformatf("vec%0d_latency", i), lat, vecs[i].exact_lat);
                else
                    check($sformatf("vec%0d_latency_max", i), (lat <= vecs[i].max_lat), 1);
                check($sformatf("vec%0d_in_ready_done", i), bus.in_ready, 0);
                release_result();
            end
        end

        // Backpressure with a second pair already waiting upstream.
        send_and_wait(64'd9, 64'd12, g, f, lat, ok);
        check("bp_valid", ok, 1);
        bus.residue  = 64'd98;
        bus.modulus  = 64'd8051;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("bp_gcd_c%0d", c), bus.gcd, 4);
            check($sformatf("bp_factor_c%0d", c), bus.factor_found, 1);
            check($sformatf("bp_in_ready_c%0d", c), bus.in_ready, 0);
            check($sformatf("bp_out_valid_c%0d", c), bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_idle_out_valid", bus.out_valid, 0);
        check("bp_idle_in_ready", bus.in_ready, 1);
        check("bp_idle_busy", bus.busy, 0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_accepted_busy", bus.busy, 1);
        lat = 1;
        while (!bus.out_valid && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_valid", bus.out_valid, 1);
        check("b2b_gcd", bus.gcd, 97);
        check("b2b_factor", bus.factor_found, 1);
        release_result();

        // Reset in the middle of a reduction.
        @(negedge clk);
        bus.residue  = 64'd98;
        bus.modulus  = 64'd8051;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy", bus.busy, 1);
        check("mid_out_valid", bus.out_valid, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mrst_out_valid", bus.out_valid, 0);
        check("mrst_in_ready", bus.in_ready, 1);
        check("mrst_busy", bus.busy, 0);
        check("mrst_gcd", bus.gcd, 0);
        repeat (3) @(negedge clk);
        check("mrst_no_result", bus.out_valid, 0);
        send_and_wait(64'd8, 64'd35, g, f, lat, ok);
        check("mrst_next_valid", ok, 1);
        check("mrst_next_gcd", g, 7);
        check("mrst_next_factor", f, 1);
        if (ok) release_result();

        // Random pairs against a Euclid reference.
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                n = {$urandom, $urandom} >> $urandom_range(0, 60);
                r = {$urandom, $urandom} >> $urandom_range(0, 60);
            end else begin
                a = 64'($urandom_range(2, 65535));
                b = 64'($urandom_range(2, 65535));
                n = a * b;
                r = (64'd1 + a * 64'($urandom_range(1, 65535))) % n;
            end
            x  = (r == 64'd0) ? n - 64'd1 : r - 64'd1;
            eg = ref_gcd(x, n);
            ef = (eg > 64'd1) && (eg < n);
            send_and_wait(r, n, g, f, lat, ok);
            check($sformatf("rnd%0d_valid", i), ok, 1);
            if (ok) begin
                check($sformatf("rnd%0d_gcd", i), g, eg);
                check($sformatf("rnd%0d_factor", i), f, ef);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                check($sformatf("rnd%0d_hold", i), bus.gcd, eg);
                release_result();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gcd_extract.md
Name: gcd_extract

Overview:
- Downstream of the modular-exponentiation stage in the Pollard p-1 datapath.
- Takes the exponentiation residue r = a^M mod n and the modulus n, and computes g = gcd(r - 1, n) with a sequential binary (Stein) GCD.
- Flags a non-trivial factor when 1 < g < n.
- Uses a valid/ready handshake on both sides so the controller can stall it.

Parameters:
- WIDTH, 64, operand width in bits; residue is zero-extended to WIDTH by the instantiating level.
- CNT_W, 7, width of the common-power-of-two counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  residue/modulus pair is valid
- in_ready  output  1  block can accept a pair
- residue  input  WIDTH  r = a^M mod n
- modulus  input  WIDTH  n
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- gcd  output  WIDTH  g = gcd(r - 1, n)
- factor_found  output  1  1 when 1 < g < n
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset: synchronous, active-high, takes priority over everything. Effects:
  - state <= IDLE; in_ready = 1; out_valid = 0; gcd = 0; factor_found = 0; busy = 0.
  - Reset mid-operation discards the computation; no result is emitted.
- States: IDLE, PREP, STRIP, REDUCE, SCALE, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, capture the operands and go to PREP:
    - x <= (residue == 0) ? modulus - 1 : residue - 1 (the modular wrap of r - 1).
    - y <= modulus; n_reg <= modulus; k <= 0.
- PREP (1 cycle):
  - If x == 0: g <= y, go to DONE.
  - Else if y == 0: g <= x, go to DONE.
  - Otherwise go to STRIP.
- STRIP (one step per cycle):
  - While x[0] == 0 and y[0] == 0: x >>= 1, y >>= 1, k++.
  - When x and y are not both even: if x is even, swap x and y so x is odd. Go to REDUCE.
- REDUCE (one step per cycle; invariant x odd):
  - If y == 0: go to SCALE.
  - Else if y[0] == 0: y >>= 1.
  - Else if x > y: x <= y, y <= x - y.
  - Else: y <= y - x.
- SCALE (1 cycle): g <= x << k; go to DONE.
- DONE:
  - out_valid = 1; gcd = g; factor_found = (g > 1) && (g < n_reg). A zero modulus gives factor_found = 0.
  - Hold all outputs stable until out_ready. On out_valid & out_ready go to IDLE.
  - in_ready = 0; no new pair is accepted in the handshake cycle.
- Outputs are registered.
- Latency (accept edge to out_valid): at least 2 cycles (PREP → DONE path); at most 2*WIDTH + 4 cycles.
- Arithmetic: all subtractions are WIDTH-bit unsigned. The compare precedes the subtract, so no underflow is reachable. k saturates never (bounded by WIDTH).
- residue >= modulus is not rejected; the GCD is computed on the wrapped x as defined above.
- modulus == 1 gives g = 1, factor_found = 0.
- in_valid while busy is ignored; the upstream stage must hold its data until in_ready.

Decomposition:
- Shared package pm1_pkg holds:
  - the state enum gcd_state_t;
  - the WIDTH default (PM1_WIDTH = 64);
  - a helper function is_nontrivial(g, n).
- One natural sub-module: gcd_step_unit, purely combinational. It takes x, y, k and the current state and produces next x, y, k plus the step-done flags (both_even, y_zero).
- gcd_extract keeps the FSM, the operand registers and the handshake.

Test Plan:
- Factor found: n = 8051 (83*97), residue = 98 → gcd = 97, factor_found = 1, out_valid within 132 cycles of acceptance.
- Trivial n: n = 8051, residue = 1 → x = 0, PREP path, gcd = 8051, factor_found = 0, out_valid 2 cycles after acceptance.
- Wrap plus trivial one: n = 8051, residue = 0 → x = 8050, gcd = 1, factor_found = 0. Also residue = 2 → gcd = 1.
- Common powers of two: n = 12, residue = 9 → gcd(8,12) = 4 with k = 2, factor_found = 1. Also n = 1<<40, residue = 1 + (1<<20) → gcd = 1<<20.
- Backpressure and handshake:
  - Hold out_ready = 0 for 10 cycles: gcd and factor_found stay stable, in_ready = 0.
  - Assert out_ready: returns to IDLE next cycle.
  - Back-to-back pairs: the second pair is accepted only after the first result's handshake.
- Reset mid-operation: assert rst while in REDUCE → next cycle out_valid = 0, in_ready = 1, busy = 0, gcd = 0. A following pair (n = 35, residue = 8) gives gcd = 7, factor_found = 1.
